// File: rtl/axis_packet_player.sv
// -----------------------------------------------------------------------------
// axis_packet_player
// AXI-Stream master that replays a preloaded frame of beats from an internal
// RAM. A frame is cfg_packets packets of cfg_beats beats; tlast marks either
// every packet end or only the frame end. Supports back-pressure at full
// throughput, looping, and clean abort.
//
// Ports
//   m00_axis_aclk / m00_axis_aresetn : clock, async active-low reset
//   wr_en / wr_addr / wr_data        : RAM load port (idle only)
//   cfg_beats / cfg_packets          : frame geometry, sampled at start
//   cfg_last_mode / cfg_loop         : tlast policy, loop enable, sampled at start
//   start / abort                    : 1-cycle control pulses
//   busy / done / beat_count         : status
//   m00_axis_t*                      : AXI-Stream master
// -----------------------------------------------------------------------------
module axis_packet_player #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      m00_axis_aclk,
  input  logic                      m00_axis_aresetn,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [CNT_WIDTH-1:0]      cfg_beats,
  input  logic [CNT_WIDTH-1:0]      cfg_packets,
  input  logic                      cfg_last_mode,
  input  logic                      cfg_loop,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [2*CNT_WIDTH-1:0]    beat_count,
  output logic                      m00_axis_tvalid,
  input  logic                      m00_axis_tready,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tlast
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BC_W   = 2 * CNT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    beats_q, beats_d, pkts_q, pkts_d;
  logic                    mode_q, mode_d, loop_q, loop_d;
  logic [CNT_WIDTH-1:0]    beat_q, beat_d, pkt_q, pkt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    abort_pend_q, abort_pend_d;
  logic                    tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [BC_W-1:0]         beat_count_q, beat_count_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    hs_s, pkt_end_s, frame_end_s;
  logic [CNT_WIDTH-1:0]    nxt_beat_s, nxt_pkt_s;
  logic [ADDR_W-1:0]       nxt_addr_s, raddr_s;

  // tlast rule for beat b of packet p under the latched configuration.
  function automatic logic is_last(input logic [CNT_WIDTH-1:0] b,
                                   input logic [CNT_WIDTH-1:0] p,
                                   input logic [CNT_WIDTH-1:0] nb,
                                   input logic [CNT_WIDTH-1:0] np,
                                   input logic                 mode);
    return (b == nb - CNT_WIDTH'(1)) && (mode || (p == np - CNT_WIDTH'(1)));
  endfunction

  assign hs_s        = tvalid_q & m00_axis_tready;
  assign pkt_end_s   = (beat_q == beats_q - CNT_WIDTH'(1));
  assign frame_end_s = pkt_end_s && (pkt_q == pkts_q - CNT_WIDTH'(1));
  assign nxt_beat_s  = pkt_end_s ? {CNT_WIDTH{1'b0}} : beat_q + CNT_WIDTH'(1);
  assign nxt_pkt_s   = pkt_end_s ? (frame_end_s ? {CNT_WIDTH{1'b0}} : pkt_q + CNT_WIDTH'(1))
                                 : pkt_q;
  // Loop wrap restarts at address 0; otherwise the address wraps modulo DEPTH.
  assign nxt_addr_s  = frame_end_s ? {ADDR_W{1'b0}} : addr_q + ADDR_W'(1);

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    pkts_d       = pkts_q;
    mode_d       = mode_q;
    loop_d       = loop_q;
    beat_d       = beat_q;
    pkt_d        = pkt_q;
    addr_d       = addr_q;
    abort_pend_d = abort_pend_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    beat_count_d = beat_count_q;
    // The RAM re-reads the presented address while stalled so tdata holds.
    raddr_s      = addr_q;
    case (state_q)
      ST_IDLE: begin
        // Abort wins over a simultaneous start.
        if (start && !abort) begin
          beats_d      = cfg_beats;
          pkts_d       = cfg_packets;
          mode_d       = cfg_last_mode;
          loop_d       = cfg_loop;
          beat_d       = {CNT_WIDTH{1'b0}};
          pkt_d        = {CNT_WIDTH{1'b0}};
          addr_d       = {ADDR_W{1'b0}};
          beat_count_d = {BC_W{1'b0}};
          abort_pend_d = 1'b0;
          tlast_d      = 1'b0;
          if ((cfg_beats == {CNT_WIDTH{1'b0}}) || (cfg_packets == {CNT_WIDTH{1'b0}})) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_FIN;
        end else begin
          state_d  = ST_STREAM;
          tvalid_d = 1'b1;
          tlast_d  = is_last(beat_q, pkt_q, beats_q, pkts_q, mode_q);
        end
      end
      ST_STREAM: begin
        if (hs_s) begin
          beat_count_d = beat_count_q + BC_W'(1);
          if (abort_pend_q || abort || (frame_end_s && !loop_q)) begin
            state_d  = ST_FIN;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            beat_d  = nxt_beat_s;
            pkt_d   = nxt_pkt_s;
            addr_d  = nxt_addr_s;
            raddr_s = nxt_addr_s;
            tlast_d = is_last(nxt_beat_s, nxt_pkt_s, beats_q, pkts_q, mode_q);
          end
        end else if (abort) begin
          // The presented beat must still complete unchanged.
          abort_pend_d = 1'b1;
        end else begin
          abort_pend_d = abort_pend_q;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // State, counters, status and AXI-S output registers.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q      <= ST_IDLE;
      beats_q      <= {CNT_WIDTH{1'b0}};
      pkts_q       <= {CNT_WIDTH{1'b0}};
      mode_q       <= 1'b0;
      loop_q       <= 1'b0;
      beat_q       <= {CNT_WIDTH{1'b0}};
      pkt_q        <= {CNT_WIDTH{1'b0}};
      addr_q       <= {ADDR_W{1'b0}};
      abort_pend_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      beat_count_q <= {BC_W{1'b0}};
      rdata_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      pkts_q       <= pkts_d;
      mode_q       <= mode_d;
      loop_q       <= loop_d;
      beat_q       <= beat_d;
      pkt_q        <= pkt_d;
      addr_q       <= addr_d;
      abort_pend_q <= abort_pend_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      beat_count_q <= beat_count_d;
      rdata_q      <= mem[raddr_s];
    end
  end

  // RAM load port; writes are dropped while a frame is in progress.
  always_ff @(posedge m00_axis_aclk) begin
    if (wr_en && (state_q == ST_IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign beat_count      = beat_count_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = rdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = {STRB_W{1'b1}};

endmodule

// File: tb/tb_axis_packet_player.sv
module tb_axis_packet_player;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic [15:0] cfg_beats, cfg_packets;
  logic        cfg_last_mode, cfg_loop;
  logic        start, abort;
  logic        busy, done;
  logic [31:0] beat_count;
  logic        tvalid, tready, tlast;
  logic [63:0] tdata;
  logic [7:0]  tstrb;

  axis_packet_player #(.DATA_WIDTH(64), .DEPTH(256), .CNT_WIDTH(16)) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_beats(cfg_beats), .cfg_packets(cfg_packets),
    .cfg_last_mode(cfg_last_mode), .cfg_loop(cfg_loop),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .beat_count(beat_count),
    .m00_axis_tvalid(tvalid), .m00_axis_tready(tready),
    .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb), .m00_axis_tlast(tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [63:0] ram_model [256];
  int m_beats, m_pkts, m_max;
  bit m_mode, m_loop;
  int gen, seen_gen;
  int start_cyc;

  // observations
  int hs_cnt, done_cnt, tlast_cnt, vld_cnt;
  int first_valid_cyc, last_hs_cyc, done_cyc;
  bit prev_stall;
  logic [63:0] prev_data;
  logic prev_last;

  int checks, errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Position k (handshake index) within the frame, after loop wrap.
  function automatic int frame_pos(int k);
    int n;
    n = m_beats * m_pkts;
    return m_loop ? (k % n) : k;
  endfunction

  function automatic logic [63:0] exp_data(int k);
    return ram_model[frame_pos(k) % 256];
  endfunction

  function automatic logic exp_last(int k);
    int j;
    j = frame_pos(k);
    return (m_mode && ((j % m_beats) == m_beats - 1)) || (j == m_beats * m_pkts - 1);
  endfunction

  task automatic mon_step();
    if (gen != seen_gen) begin
      seen_gen = gen;
      hs_cnt = 0; done_cnt = 0; tlast_cnt = 0; vld_cnt = 0;
      first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    end
    if (!rst_n) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("hold_valid", {63'd0, tvalid}, 64'd1);
      chk("hold_data", tdata, prev_data);
      chk("hold_last", {63'd0, tlast}, {63'd0, prev_last});
    end
    if (tvalid) begin
      vld_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hs_cnt >= m_max) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got beat index %0d, expected at most %0d beats", hs_cnt, m_max);
      end else begin
        chk("tdata", tdata, exp_data(hs_cnt));
        chk("tlast", {63'd0, tlast}, {63'd0, exp_last(hs_cnt)});
      end
      if (tready) begin
        if (tlast) tlast_cnt++;
        hs_cnt++;
        last_hs_cyc = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = tvalid & ~tready;
    prev_data  = tdata;
    prev_last  = tlast;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int b, input int p, input bit mode, input bit lp, input int maxb);
    cfg_beats = 16'(b); cfg_packets = 16'(p);
    cfg_last_mode = mode; cfg_loop = lp;
    m_beats = b; m_pkts = p; m_mode = mode; m_loop = lp; m_max = maxb;
    gen++;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (rnd) tready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("done_seen", {63'd0, (done_cnt > 0)}, 64'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("done_once", 64'(done_cnt), 64'd1);
    tready = 1'b1;
  endtask

  task automatic end_checks(input int n, input int nlast);
    chk("beats_seen", 64'(hs_cnt), 64'(n));
    chk("beat_count", 64'(beat_count), 64'(n));
    chk("tlast_count", 64'(tlast_cnt), 64'(nlast));
    chk("done_after_last", 64'(done_cyc), 64'(last_hs_cyc + 1));
    chk("first_latency", 64'(first_valid_cyc), 64'(start_cyc + 2));
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 64'd0;
    cfg_beats = 16'd0; cfg_packets = 16'd0; cfg_last_mode = 1'b0; cfg_loop = 1'b0;
    start = 1'b0; abort = 1'b0; tready = 1'b1;
    gen = 0; seen_gen = -1; m_max = 0; m_beats = 1; m_pkts = 1; m_mode = 1'b0; m_loop = 1'b0;
    checks = 0; errors = 0; prev_stall = 1'b0; start_cyc = 0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
      begin
        // reset state
        tick(); tick();
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_tlast", {63'd0, tlast}, 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_beat_count", 64'(beat_count), 64'd0);
        chk("rst_tstrb", 64'(tstrb), 64'hFF);
        rst_n = 1'b1;
        tick();

        // load RAM[i] = i
        for (int i = 0; i < 256; i++) begin
          wr_en = 1'b1; wr_addr = 8'(i); wr_data = 64'(i);
          ram_model[i] = 64'(i);
          tick();
        end
        wr_en = 1'b0;

        // 10x13, tlast on frame end only
        tready = 1'b1;
        start_frame(10, 13, 1'b0, 1'b0, 130);
        chk("model_data129", exp_data(129), 64'd129);
        chk("model_last129", {63'd0, exp_last(129)}, 64'd1);
        chk("model_last9", {63'd0, exp_last(9)}, 64'd0);
        wait_done(400, 1'b0);
        end_checks(130, 1);
        chk("full_rate", 64'(last_hs_cyc - first_valid_cyc), 64'd129);

        // 4x3, tlast on every packet end
        start_frame(4, 3, 1'b1, 1'b0, 12);
        chk("model_last3", {63'd0, exp_last(3)}, 64'd1);
        chk("model_last4", {63'd0, exp_last(4)}, 64'd0);
        wait_done(100, 1'b0);
        end_checks(12, 3);

        // 1000-beat frame with random back-pressure
        start_frame(100, 10, 1'b0, 1'b0, 1000);
        chk("model_wrap", exp_data(300), 64'd44);
        wait_done(8000, 1'b1);
        end_checks(1000, 1);

        // 2x5 loop, then abort with a stalled beat pending
        start_frame(2, 5, 1'b1, 1'b1, 1 << 30);
        for (int i = 0; i < 200 && hs_cnt < 23; i++) tick();
        tready = 1'b0;
        tick(); tick();
        chk("pending_valid", {63'd0, tvalid}, 64'd1);
        abort = 1'b1;
        m_max = hs_cnt + 1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("abort_held_busy", {63'd0, busy}, 64'd1);
        tready = 1'b1;
        wait_done(50, 1'b0);
        chk("abort_beats", 64'(hs_cnt), 64'(m_max));
        chk("abort_beat_count", 64'(beat_count), 64'(m_max));
        chk("abort_done_after_last", 64'(done_cyc), 64'(last_hs_cyc + 1));

        // zero-length frame
        start_frame(0, 5, 1'b0, 1'b0, 0);
        wait_done(20, 1'b0);
        chk("zero_done_latency", 64'(done_cyc), 64'(start_cyc + 1));
        chk("zero_no_valid", 64'(vld_cnt), 64'd0);
        chk("zero_beat_count", 64'(beat_count), 64'd0);

        // start while busy is ignored; write while busy is dropped
        start_frame(3, 4, 1'b0, 1'b0, 12);
        for (int i = 0; i < 4; i++) tick();
        cfg_beats = 16'd1; cfg_packets = 16'd1; start = 1'b1;
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        start = 1'b0; wr_en = 1'b0;
        wait_done(100, 1'b0);
        end_checks(12, 1);

        // start and abort together while idle
        gen++; m_max = 0;
        cfg_beats = 16'd4; cfg_packets = 16'd4; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("sa_busy", {63'd0, busy}, 64'd0);
        chk("sa_done", 64'(done_cnt), 64'd0);
        chk("sa_valid", 64'(vld_cnt), 64'd0);

        // write and start in the same idle cycle: write lands first
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 64'hDEAD_BEEF_0000_0001;
        ram_model[0] = 64'hDEAD_BEEF_0000_0001;
        start_frame(2, 1, 1'b0, 1'b0, 2);
        wr_en = 1'b0;
        wait_done(50, 1'b0);
        end_checks(2, 1);

        // reset mid-frame
        start_frame(10, 13, 1'b0, 1'b0, 130);
        for (int i = 0; i < 20; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_beat_count", 64'(beat_count), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_rst_no_done", 64'(done_cnt), 64'd0);

        // replay after reset starts from RAM[0]
        start_frame(3, 2, 1'b1, 1'b0, 6);
        chk("model_replay0", exp_data(0), 64'hDEAD_BEEF_0000_0001);
        chk("model_replay5", exp_data(5), 64'd5);
        wait_done(50, 1'b0);
        end_checks(6, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    join_any
  end

endmodule
